// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a two-flop input synchronizer,
// mid-bit sampling, framing-error detection and break (line held low)
// handling. All receive decisions are taken on the synchronized line rx_s.
module uart_rx #(
  parameter int BAUD_RATE  = 115200,
  parameter int CLOCK_FREQ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int BAUD_COUNT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_COUNT = BAUD_COUNT / 2;
  // Counter is never narrower than 16 bits, wider only if a bit period needs it.
  localparam int CNT_W = ($clog2(BAUD_COUNT + 1) > 16) ? $clog2(BAUD_COUNT + 1) : 16;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_COUNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       rx_data_reg, rx_data_next;
  logic             rx_valid_reg, rx_valid_next;
  logic             frame_err_reg, frame_err_next;
  logic             rx_meta_reg;
  logic             rx_s;

  // Two-flop synchronizer; both stages reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_s        <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s        <= rx_meta_reg;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // Next-state logic; the baud counter restarts from zero on every transition.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg + 1'b1;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    rx_data_next   = rx_data_reg;
    rx_valid_next  = 1'b0;
    frame_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end else begin
            // Start bit did not hold to mid-bit: a glitch, drop it silently.
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_reg == BAUD_LAST) begin
          cnt_next     = '0;
          shift_next   = {rx_s, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 1'b1;
          if (bit_idx_reg == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt_reg == BAUD_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            rx_data_next  = shift_reg;
            rx_valid_next = 1'b1;
            state_next    = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = BREAK;
          end
        end
      end
      BREAK: begin
        // Wait out a line held low so it reports only one framing error.
        cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign rx_busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed stimulus for uart_rx with a scoreboard of expected
// receive events ({is_frame_err, rx_data}) checked as the DUT pulses.
module tb_uart_rx;

  localparam int CF = 1_000_000;
  localparam int BR = 100_000;
  localparam int BC = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int drive_cyc = 0;
  logic [8:0] sb[$];
  int valid_cyc[$];

  uart_rx #(.BAUD_RATE(BR), .CLOCK_FREQ(CF)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one frame; caller is aligned to a falling clock edge.
  task automatic send_bits(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    drive_cyc = cyc;
    repeat (BC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BC) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BC) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    sb.push_back({1'b0, d});
    send_bits(d, 1'b1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  initial begin
    logic [8:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rx_valid || frame_err) begin
        check("exclusive", int'(rx_valid & frame_err), 0);
        check("expected_pulse", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("kind", int'(frame_err), int'(e[8]));
          check("data", int'(rx_data), int'(e[7:0]));
        end
        if (rx_valid) valid_cyc.push_back(cyc);
        $display("rx %s data=%02h cycle=%0d", rx_valid ? "valid" : "frame_err", rx_data, cyc);
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int gap;
    // Reset state
    repeat (5) @(negedge clk);
    check("rst_data", int'(rx_data), 0);
    check("rst_valid", int'(rx_valid), 0);
    check("rst_err", int'(frame_err), 0);
    check("rst_busy", int'(rx_busy), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single frame 0xA5 with latency check
    valid_cyc.delete();
    send_byte(8'hA5);
    wait_drain(50);
    check("a5_count", valid_cyc.size(), 1);
    lat = (valid_cyc.size() > 0) ? valid_cyc[0] - drive_cyc : 0;
    check("a5_latency", int'(lat >= 97 && lat <= 99), 1);
    repeat (3) @(negedge clk);
    check("a5_idle", int'(rx_busy), 0);

    // Back-to-back 0x00, 0xFF with no idle gap
    valid_cyc.delete();
    send_byte(8'h00);
    send_byte(8'hFF);
    wait_drain(50);
    check("b2b_count", valid_cyc.size(), 2);
    gap = (valid_cyc.size() == 2) ? valid_cyc[1] - valid_cyc[0] : 0;
    check("b2b_gap", int'(gap >= 99 && gap <= 101), 1);

    // Short glitch on the line
    repeat (5) @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check("glitch_idle", int'(rx_busy), 0);
    check("glitch_data", int'(rx_data), 8'hFF);

    // Framing error keeps prior data, then a good 0x11
    sb.push_back({1'b1, 8'hFF});
    send_bits(8'h3C, 1'b0);
    wait_drain(50);
    repeat (10) @(negedge clk);
    check("ferr_idle", int'(rx_busy), 0);
    send_byte(8'h11);
    wait_drain(50);

    // Break: line held low for 300 clk
    repeat (5) @(negedge clk);
    sb.push_back({1'b1, 8'h11});
    rx = 1'b0;
    repeat (200) @(negedge clk);
    check("break_busy_mid", int'(rx_busy), 1);
    repeat (100) @(negedge clk);
    check("break_busy_end", int'(rx_busy), 1);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check("break_idle", int'(rx_busy), 0);
    check("break_one_err", sb.size(), 0);

    // Reset during data bit 4 of a frame
    rx = 1'b0;
    repeat (BC) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (BC) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BC / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_data", int'(rx_data), 0);
    check("mrst_valid", int'(rx_valid), 0);
    check("mrst_err", int'(frame_err), 0);
    check("mrst_busy", int'(rx_busy), 0);
    repeat (150) @(negedge clk);
    check("mrst_quiet", int'(rx_busy), 0);
    send_byte(8'h7E);
    wait_drain(50);
    repeat (5) @(negedge clk);
    check("final_data", int'(rx_data), 8'h7E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
